// File: rtl/wb_rr_mem_arbiter.sv
// Round-robin Wishbone B3 arbiter sharing the main-RAM slave among N masters.
// Optional slave no-response timeout enabled by `define WB_ARB_TIMEOUT_EN.
module wb_rr_mem_arbiter #(
  parameter int NUM_MASTERS    = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic [32*NUM_MASTERS-1:0]  m_adr_i,
  input  logic [32*NUM_MASTERS-1:0]  m_dat_i,
  input  logic [4*NUM_MASTERS-1:0]   m_sel_i,
  input  logic [NUM_MASTERS-1:0]     m_we_i,
  input  logic [NUM_MASTERS-1:0]     m_cyc_i,
  input  logic [NUM_MASTERS-1:0]     m_stb_i,
  input  logic [3*NUM_MASTERS-1:0]   m_cti_i,
  input  logic [2*NUM_MASTERS-1:0]   m_bte_i,
  output logic [31:0]                m_dat_o,
  output logic [NUM_MASTERS-1:0]     m_ack_o,
  output logic [NUM_MASTERS-1:0]     m_err_o,
  output logic [NUM_MASTERS-1:0]     m_rty_o,
  output logic [31:0]                s_adr_o,
  output logic [31:0]                s_dat_o,
  output logic [3:0]                 s_sel_o,
  output logic                       s_we_o,
  output logic                       s_cyc_o,
  output logic                       s_stb_o,
  output logic [2:0]                 s_cti_o,
  output logic [1:0]                 s_bte_o,
  input  logic [31:0]                s_dat_i,
  input  logic                       s_ack_i,
  input  logic                       s_err_i,
  input  logic                       s_rty_i,
  output logic [NUM_MASTERS-1:0]     grant_o
);

  localparam int N  = NUM_MASTERS;
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t          r_state;
  logic [N-1:0]    r_grant;
  logic [PW-1:0]   r_ptr;

  logic [N-1:0]    w_next;
  logic [PW-1:0]   w_gidx;
  logic            w_gcyc;
  logic            w_stb_raw;
  logic            w_tmo_hit;
  logic [31:0]     w_adr;
  logic [31:0]     w_dat;
  logic [3:0]      w_sel;
  logic            w_we;
  logic [2:0]      w_cti;
  logic [1:0]      w_bte;

  if (NUM_MASTERS < 1 || NUM_MASTERS > 16 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
  end

  // First requester strictly after the last-served index, wrapping.
  always_comb begin
    logic found;
    found  = 1'b0;
    w_next = '0;
    for (int i = 1; i <= N; i++) begin
      if (!found && m_cyc_i[(int'(r_ptr) + i) % N]) begin
        w_next[(int'(r_ptr) + i) % N] = 1'b1;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    w_gidx    = '0;
    w_gcyc    = 1'b0;
    w_stb_raw = 1'b0;
    w_adr     = '0;
    w_dat     = '0;
    w_sel     = '0;
    w_we      = 1'b0;
    w_cti     = '0;
    w_bte     = '0;
    for (int i = 0; i < N; i++) begin
      if (r_grant[i]) begin
        w_gidx    = PW'(i);
        w_gcyc    = m_cyc_i[i];
        w_stb_raw = m_stb_i[i] & m_cyc_i[i];
        w_adr     = m_adr_i[32*i +: 32];
        w_dat     = m_dat_i[32*i +: 32];
        w_sel     = m_sel_i[4*i +: 4];
        w_we      = m_we_i[i];
        w_cti     = m_cti_i[3*i +: 3];
        w_bte     = m_bte_i[2*i +: 2];
      end
    end
  end

  assign s_adr_o = w_adr;
  assign s_dat_o = w_dat;
  assign s_sel_o = w_sel;
  assign s_we_o  = w_we;
  assign s_cti_o = w_cti;
  assign s_bte_o = w_bte;
  assign s_cyc_o = w_gcyc & ~w_tmo_hit;
  assign s_stb_o = w_stb_raw & ~w_tmo_hit;

  assign m_dat_o = s_dat_i;
  assign m_ack_o = r_grant & {N{s_ack_i & ~w_tmo_hit}};
  assign m_rty_o = r_grant & {N{s_rty_i & ~w_tmo_hit}};
  assign m_err_o = r_grant & {N{s_err_i | w_tmo_hit}};
  assign grant_o = r_grant;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_ptr   <= PW'(N - 1);
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (|m_cyc_i) begin
            r_grant <= w_next;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (!w_gcyc || w_tmo_hit) begin
            r_grant <= '0;
            r_ptr   <= w_gidx;
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_tmo;
  logic        w_resp;

  assign w_resp = s_ack_i | s_err_i | s_rty_i;

  // Hit does not look at the slave response, keeping stb free of a loop.
  assign w_tmo_hit = (r_state == ST_GRANT) & w_stb_raw &
                     (r_tmo == TMO_LAST);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || r_state == ST_IDLE || w_resp || w_tmo_hit)
      r_tmo <= '0;
    else if (w_stb_raw)
      r_tmo <= r_tmo + 16'd1;
  end
`else
  assign w_tmo_hit = 1'b0;
`endif

endmodule

// File: tb/tb_wb_rr_mem_arbiter.sv
// Directed self-checking bench for wb_rr_mem_arbiter (N=3, timeout 8).
// Slave model responds combinationally; inputs change on negedge.
module tb_wb_rr_mem_arbiter;

  localparam int N = 3;

  logic          clk;
  logic          rst;
  logic [32*N-1:0] m_adr;
  logic [32*N-1:0] m_dat;
  logic [4*N-1:0]  m_sel;
  logic [N-1:0]    m_we;
  logic [N-1:0]    m_cyc;
  logic [N-1:0]    m_stb;
  logic [3*N-1:0]  m_cti;
  logic [2*N-1:0]  m_bte;
  logic [31:0]     m_dat_o;
  logic [N-1:0]    m_ack_o;
  logic [N-1:0]    m_err_o;
  logic [N-1:0]    m_rty_o;
  logic [31:0]     s_adr_o;
  logic [31:0]     s_dat_o;
  logic [3:0]      s_sel_o;
  logic            s_we_o;
  logic            s_cyc_o;
  logic            s_stb_o;
  logic [2:0]      s_cti_o;
  logic [1:0]      s_bte_o;
  logic [31:0]     s_dat_i;
  logic            s_ack_i;
  logic            s_err_i;
  logic            s_rty_i;
  logic [N-1:0]    grant_o;

  logic ack_en;
  logic err_en;

  int n_chk;
  int n_fail;
  int n_ack1;
  int n_ack2;

  assign s_ack_i = ack_en & s_cyc_o & s_stb_o;
  assign s_err_i = err_en & s_cyc_o & s_stb_o;
  assign s_rty_i = 1'b0;
  assign s_dat_i = s_adr_o ^ 32'h5A5A_0000;

  wb_rr_mem_arbiter #(
    .NUM_MASTERS    (N),
    .TIMEOUT_CYCLES (8)
  ) u_dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .m_adr_i  (m_adr),
    .m_dat_i  (m_dat),
    .m_sel_i  (m_sel),
    .m_we_i   (m_we),
    .m_cyc_i  (m_cyc),
    .m_stb_i  (m_stb),
    .m_cti_i  (m_cti),
    .m_bte_i  (m_bte),
    .m_dat_o  (m_dat_o),
    .m_ack_o  (m_ack_o),
    .m_err_o  (m_err_o),
    .m_rty_o  (m_rty_o),
    .s_adr_o  (s_adr_o),
    .s_dat_o  (s_dat_o),
    .s_sel_o  (s_sel_o),
    .s_we_o   (s_we_o),
    .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o),
    .s_cti_o  (s_cti_o),
    .s_bte_o  (s_bte_o),
    .s_dat_i  (s_dat_i),
    .s_ack_i  (s_ack_i),
    .s_err_i  (s_err_i),
    .s_rty_i  (s_rty_i),
    .grant_o  (grant_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    m_cyc = '0;
    m_stb = '0;
    @(negedge clk);
    rst   = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    m_adr  = '0;
    m_dat  = '0;
    m_sel  = '1;
    m_we   = '0;
    m_cyc  = '0;
    m_stb  = '0;
    m_cti  = '0;
    m_bte  = '0;
    ack_en = 1'b1;
    err_en = 1'b0;
    @(negedge clk);

    // 1: reset state and single read
    do_reset();
    chk("rst_grant", 32'(grant_o), 32'h0);
    chk("rst_scyc",  32'(s_cyc_o), 32'h0);
    chk("rst_ack",   32'(m_ack_o), 32'h0);
    chk("rst_err",   32'(m_err_o), 32'h0);
    m_adr[31:0] = 32'h100;
    m_cyc = 3'b001;
    m_stb = 3'b001;
    #1;
    chk("t1_lat0",  32'(s_cyc_o), 32'h0);
    @(negedge clk);
    chk("t1_scyc",  32'(s_cyc_o), 32'h1);
    chk("t1_adr",   s_adr_o,      32'h100);
    chk("t1_grant", 32'(grant_o), 32'h1);
    chk("t1_ack",   32'(m_ack_o), 32'h1);
    chk("t1_rty",   32'(m_rty_o), 32'h0);
    chk("t1_dat",   m_dat_o,      32'h5A5A_0100);
    m_cyc = '0;
    m_stb = '0;
    @(negedge clk);
    chk("t1_rel",   32'(grant_o), 32'h0);

    // 2: all three requesting, rotation with a turnaround
    do_reset();
    m_cyc = 3'b111;
    m_stb = 3'b111;
    for (int r = 0; r < 6; r++) begin
      @(negedge clk);
      chk("t2_grant", 32'(grant_o), 32'(1 << (r % 3)));
      chk("t2_ack",   32'(m_ack_o), 32'(1 << (r % 3)));
      m_cyc = m_cyc & ~grant_o;
      m_stb = m_cyc;
      @(negedge clk);
      chk("t2_gap",   32'(s_cyc_o), 32'h0);
      m_cyc = 3'b111;
      m_stb = 3'b111;
    end

    // 3: master 1 burst holds grant against master 2
    do_reset();
    n_ack1 = 0;
    n_ack2 = 0;
    m_adr[63:32] = 32'h200;
    m_adr[95:64] = 32'h300;
    m_cti[5:3]   = 3'b010;
    m_cti[8:6]   = 3'b000;
    m_cyc = 3'b110;
    m_stb = 3'b110;
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      chk("t3_adr", s_adr_o, 32'h200 + 32'(4 * b));
      chk("t3_cti", 32'(s_cti_o), (b == 7) ? 32'h7 : 32'h2);
      if (m_ack_o[1]) n_ack1++;
      if (m_ack_o[2]) n_ack2++;
      m_adr[63:32] = m_adr[63:32] + 32'h4;
      if (b == 6) m_cti[5:3] = 3'b111;
    end
    chk("t3_n1", 32'(n_ack1), 32'h8);
    chk("t3_n2", 32'(n_ack2), 32'h0);
    m_cyc = 3'b100;
    m_stb = 3'b100;
    @(negedge clk);
    chk("t3_gap",  32'(grant_o), 32'h0);
    @(negedge clk);
    chk("t3_g2",   32'(grant_o), 32'h4);
    chk("t3_ack2", 32'(m_ack_o), 32'h4);
    m_cyc = '0;
    m_stb = '0;
    @(negedge clk);

    // 4: slave error on master 2 write, release meets new request
    ack_en = 1'b0;
    err_en = 1'b1;
    m_we   = 3'b100;
    m_dat[95:64] = 32'hDEAD_BEEF;
    m_cyc = 3'b100;
    m_stb = 3'b100;
    @(negedge clk);
    chk("t4_err", 32'(m_err_o), 32'h4);
    chk("t4_ack", 32'(m_ack_o), 32'h0);
    chk("t4_we",  32'(s_we_o),  32'h1);
    chk("t4_dat", s_dat_o,      32'hDEAD_BEEF);
    ack_en = 1'b1;
    err_en = 1'b0;
    m_we   = '0;
    m_cti  = '0;
    m_cyc  = 3'b001;
    m_stb  = 3'b001;
    @(negedge clk);
    chk("t4_gap",   32'(s_cyc_o), 32'h0);
    @(negedge clk);
    chk("t4_grant", 32'(grant_o), 32'h1);
    chk("t4_ack0",  32'(m_ack_o), 32'h1);

    // 5: reset in the middle of a burst
    m_cti[2:0] = 3'b010;
    @(negedge clk);
    chk("t5_beat", 32'(m_ack_o), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_grant", 32'(grant_o), 32'h0);
    chk("t5_scyc",  32'(s_cyc_o), 32'h0);
    chk("t5_ack",   32'(m_ack_o), 32'h0);
    rst   = 1'b0;
    m_cyc = 3'b011;
    m_stb = 3'b011;
    @(negedge clk);
    chk("t5_win0", 32'(grant_o), 32'h1);
    m_cyc = '0;
    m_stb = '0;
    m_cti = '0;
    @(negedge clk);

    // 6: slave never responds
    ack_en = 1'b0;
    m_adr[63:32] = 32'h400;
    m_cyc = 3'b010;
    m_stb = 3'b010;
`ifdef WB_ARB_TIMEOUT_EN
    for (int c = 1; c < 8; c++) begin
      @(negedge clk);
      chk("t6_noerr", 32'(m_err_o), 32'h0);
    end
    @(negedge clk);
    chk("t6_err",  32'(m_err_o), 32'h2);
    chk("t6_scyc", 32'(s_cyc_o), 32'h0);
    m_cyc = '0;
    m_stb = '0;
    @(negedge clk);
    chk("t6_idle", 32'(grant_o), 32'h0);
`else
    repeat (100) @(negedge clk);
    chk("t6_hold", 32'(grant_o), 32'h2);
    chk("t6_scyc", 32'(s_cyc_o), 32'h1);
    chk("t6_err",  32'(m_err_o), 32'h0);
    m_cyc = '0;
    m_stb = '0;
    @(negedge clk);
    chk("t6_idle", 32'(grant_o), 32'h0);
`endif
    ack_en = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
